// File: rtl/div3_seq.sv
// Multi-cycle divider by 3: MSB-first long division, CHUNK bits per cycle, giving quotient and remainder.
// Optional macro DIV3_EXACT_CHK_EN adds the registered output err = (remainder != 0).
module div3_seq #(
  parameter int WIDTH = 1024,
  parameter int CHUNK = 64
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] in_a,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] out_q,
`ifdef DIV3_EXACT_CHK_EN
  output logic             err,
`endif
  output logic [1:0]       out_r
);
  localparam int N  = WIDTH / CHUNK;
  localparam int CW = $clog2(N + 1);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_FIN} state_t;

  state_t           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] div_q, div_d;
  logic [WIDTH-1:0] quo_q, quo_d;
  logic [1:0]       rem_q, rem_d;
  logic             done_q;
  logic [WIDTH-1:0] outq_q;
  logic [1:0]       outr_q;

  // Bit-serial restoring division of the top chunk. Because the remainder never
  // exceeds 2, each step only needs a 3-bit compare and subtract.
  logic [CHUNK-1:0] qc;
  logic [1:0]       rc;
  logic [2:0]       t;
  always_comb begin
    qc = '0;
    rc = rem_q;
    t  = '0;
    for (int i = CHUNK - 1; i >= 0; i--) begin
      t = {rc, div_q[WIDTH-CHUNK+i]};
      if (t >= 3'd3) begin
        qc[i] = 1'b1;
        t     = t - 3'd3;
      end
      rc = t[1:0];
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      div_q   <= '0;
      quo_q   <= '0;
      rem_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      div_q   <= div_d;
      quo_q   <= quo_d;
      rem_q   <= rem_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    div_d   = div_q;
    quo_d   = quo_q;
    rem_d   = rem_q;
    case (state_q)
      S_IDLE: begin
        // The cycle in which done is high still rejects start.
        if (start && !done_q) begin
          div_d   = in_a;
          quo_d   = '0;
          rem_d   = '0;
          cnt_d   = '0;
          state_d = S_RUN;
        end
      end
      S_RUN: begin
        div_d = div_q << CHUNK;
        quo_d = (quo_q << CHUNK) | WIDTH'(qc);
        rem_d = rc;
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == CW'(N - 1)) state_d = S_FIN;
      end
      S_FIN:   state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    busy = (state_q == S_RUN);
  end

  // Result registers are loaded only when leaving FIN, so a later run leaves them untouched.
  always_ff @(posedge clk) begin
    if (reset) begin
      done_q <= 1'b0;
      outq_q <= '0;
      outr_q <= '0;
    end else begin
      done_q <= (state_q == S_FIN);
      if (state_q == S_FIN) begin
        outq_q <= quo_q;
        outr_q <= rem_q;
      end
    end
  end

`ifdef DIV3_EXACT_CHK_EN
  logic err_q;
  always_ff @(posedge clk) begin
    if (reset)                  err_q <= 1'b0;
    else if (state_q == S_FIN)  err_q <= (rem_q != 2'd0);
  end
  assign err = err_q;
`endif

  assign done  = done_q;
  assign out_q = outq_q;
  assign out_r = outr_q;
endmodule

// File: tb/tb_div3_seq.sv
// Bench for div3_seq: a cycle-level behavioural model compared against the DUT on every cycle,
// plus directed operands with expected results worked out by hand.
module tb_div3_seq;
  localparam int W = 1024;
  localparam int C = 64;
  localparam int N = W / C;

  logic         clk = 1'b0;
  logic         reset, start;
  logic [W-1:0] in_a;
  logic         busy, done;
  logic [W-1:0] out_q;
  logic [1:0]   out_r;
`ifdef DIV3_EXACT_CHK_EN
  logic         err;
`endif

  div3_seq #(.WIDTH(W), .CHUNK(C)) dut (
    .clk(clk), .reset(reset), .start(start), .in_a(in_a),
    .busy(busy), .done(done), .out_q(out_q),
`ifdef DIV3_EXACT_CHK_EN
    .err(err),
`endif
    .out_r(out_r)
  );

  always #5 clk = ~clk;

  int total = 0, passed = 0;
  bit chk_en = 1'b0;

  task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %h expected %h (low 128 bits)", name, act[127:0], exp[127:0]);
  endtask

  // Model: an accepted operation finishes N+1 edges after it is accepted; busy covers the first N cycles.
  logic [W-1:0] m_op, m_q;
  logic [1:0]   m_r;
  logic         m_act, m_done, m_busy, m_err;
  int           m_age;
  always @(posedge clk) begin
    if (reset) begin
      m_act = 0; m_age = 0; m_done = 0; m_q = '0; m_r = '0; m_err = 0; m_op = '0;
    end else if (m_act) begin
      m_age++;
      m_done = 0;
      if (m_age == N + 1) begin
        m_act  = 0;
        m_done = 1;
        m_q    = m_op / 3;
        m_r    = 2'(m_op % 3);
        m_err  = (m_r != 2'd0);
      end
    end else if (start && !m_done) begin
      m_act = 1; m_age = 0; m_op = in_a; m_done = 0;
    end else begin
      m_done = 0;
    end
    m_busy = m_act && (m_age < N);
  end

  always @(negedge clk) begin
    if (chk_en) begin
      check("busy", W'(busy), W'(m_busy));
      check("done", W'(done), W'(m_done));
      check("out_q", out_q, m_q);
      check("out_r", W'(out_r), W'(m_r));
`ifdef DIV3_EXACT_CHK_EN
      check("err", W'(err), W'(m_err));
`endif
    end
  end

  task automatic run_op(input logic [W-1:0] a, output int lat, output int bc);
    @(negedge clk);
    start = 1'b1;
    in_a  = a;
    @(negedge clk);
    start = 1'b0;
    lat = 0;
    bc  = 0;
    while (!done && lat < 40) begin
      if (busy) bc++;
      @(negedge clk);
      lat++;
    end
  endtask

  logic [W-1:0] v, x, rnd, lit;
  int lat, bc, dcnt;

  initial begin
    reset = 1'b1; start = 1'b0; in_a = '0;
    repeat (3) @(negedge clk);
    check("rst_busy", W'(busy), '0);
    check("rst_done", W'(done), '0);
    check("rst_q", out_q, '0);
    check("rst_r", W'(out_r), '0);
    chk_en = 1'b1;
    reset  = 1'b0;

    // Zero operand: latency and busy length.
    run_op('0, lat, bc);
    check("zero_lat", W'(lat), W'(17));
    check("zero_busy", W'(bc), W'(16));
    check("zero_q", out_q, '0);
    check("zero_r", W'(out_r), '0);
`ifdef DIV3_EXACT_CHK_EN
    check("zero_err", W'(err), '0);
`endif

    // All ones.
    v = '1;
    run_op(v, lat, bc);
    lit = {256{4'h5}};
    check("ones_q", out_q, lit);
    check("ones_r", W'(out_r), '0);
    check("ones_model", m_q, lit);

    // 2^1023.
    v = '0; v[W-1] = 1'b1;
    run_op(v, lat, bc);
    lit = {4'h2, {255{4'hA}}};
    check("msb_q", out_q, lit);
    check("msb_r", W'(out_r), W'(2));
`ifdef DIV3_EXACT_CHK_EN
    check("msb_err", W'(err), W'(1));
`endif

    // Small operand.
    v = W'(7);
    run_op(v, lat, bc);
    check("seven_q", out_q, W'(2));
    check("seven_r", W'(out_r), W'(1));

    // Back-to-back exact multiples.
    for (int k = 0; k < 100; k++) begin
      for (int j = 0; j < W / 32; j++) rnd[j*32 +: 32] = $urandom;
      x = rnd / 3;
      run_op(x * 3, lat, bc);
      check("mul3_q", out_q, x);
      check("mul3_r", W'(out_r), '0);
      check("mul3_lat", W'(lat), W'(17));
    end

    // start re-pulsed during RUN must be ignored.
    for (int j = 0; j < W / 32; j++) rnd[j*32 +: 32] = $urandom;
    x = rnd / 3;
    @(negedge clk); start = 1'b1; in_a = x * 3;
    @(negedge clk); start = 1'b0;
    dcnt = 0;
    for (int c = 1; c <= 30; c++) begin
      if (c == 3 || c == 10) begin start = 1'b1; in_a = ~in_a; end
      else start = 1'b0;
      @(negedge clk);
      if (done) begin
        dcnt++;
        check("ign_q", out_q, x);
      end
    end
    start = 1'b0;
    check("ign_dcnt", W'(dcnt), W'(1));

    // Reset at RUN cycle 8 aborts the operation.
    @(negedge clk); start = 1'b1; in_a = W'(12345);
    @(negedge clk); start = 1'b0;
    repeat (7) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check("abort_busy", W'(busy), '0);
    check("abort_q", out_q, '0);
    check("abort_r", W'(out_r), '0);
    dcnt = 0;
    repeat (25) begin
      @(negedge clk);
      if (done) dcnt++;
    end
    check("abort_nodone", W'(dcnt), '0);
    run_op(W'(12345), lat, bc);
    check("after_lat", W'(lat), W'(17));
    check("after_q", out_q, W'(4115));
    check("after_r", W'(out_r), '0);

    @(negedge clk);
    chk_en = 1'b0;
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
